// File: rtl/traffic_light_ctrl_pkg.sv
// ============================================================================
// Module : traffic_light_pkg
// Brief  : State encoding and default phase timing for traffic_light_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_light_pkg;

    localparam int STATE_W        = 3;
    localparam int CNT_W_DEF      = 12;
    localparam int LONG_TIME_DEF  = 10;
    localparam int SHORT_TIME_DEF = 5;

    typedef enum logic [STATE_W-1:0] {
        HWY_GREEN   = 3'd0,
        HWY_YELLOW  = 3'd1,
        FARM_GREEN  = 3'd2,
        FARM_YELLOW = 3'd3,
        FLASH       = 3'd4
    } tl_state_t;

endpackage : traffic_light_pkg

`default_nettype wire

// File: rtl/traffic_light_ctrl_if.sv
// ============================================================================
// Module : traffic_light_ctrl_if
// Brief  : Sensor/request inputs and lamp/debug outputs of the controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface traffic_light_ctrl_if;
    import traffic_light_pkg::*;

    logic               start;
    logic               c;
    logic               ped_req;
    logic               HG, HY, HR;
    logic               FG, FY, FR;
    logic               WALK;
    logic [STATE_W-1:0] state;

    modport master (
        output start, c, ped_req,
        input  HG, HY, HR, FG, FY, FR, WALK, state
    );

    modport slave (
        input  start, c, ped_req,
        output HG, HY, HR, FG, FY, FR, WALK, state
    );
endinterface : traffic_light_ctrl_if

`default_nettype wire

// File: rtl/traffic_light_ctrl_phase_timer.sv
// ============================================================================
// Module : phase_timer
// Brief  : Loadable down-counter that saturates at zero; done when zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int               CNT_W     = 12,
    parameter logic [CNT_W-1:0] RST_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_value,
    output logic                  o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RST_VALUE;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule : phase_timer

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// Module : traffic_light_ctrl
// Brief  : Highway/farm-road light controller with pedestrian walk and flash.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LONG_TIME  = LONG_TIME_DEF,
    parameter int SHORT_TIME = SHORT_TIME_DEF
) (
    input  wire logic            clk,
    input  wire logic            reset,
    traffic_light_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_LONG_LOAD  = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] c_SHORT_LOAD = CNT_W'(SHORT_TIME - 1);

    generate
        if (SHORT_TIME < 1 || LONG_TIME < 1 ||
            longint'(SHORT_TIME) > (longint'(1) << CNT_W) ||
            longint'(LONG_TIME)  > (longint'(1) << CNT_W)) begin : g_param_err
            $error("traffic_light_ctrl: phase durations out of range for CNT_W");
        end
    endgenerate

    tl_state_t        r_state, w_next_state;
    logic             r_ped_pending, w_ped_next;
    logic             r_walk, w_walk_next;
    logic             r_flash_phase, w_flash_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_value;
    logic             w_done;

    phase_timer #(
        .CNT_W     (CNT_W),
        .RST_VALUE (c_LONG_LOAD)
    ) u_phase_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_done       (w_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= HWY_GREEN;
            r_ped_pending <= 1'b0;
            r_walk        <= 1'b0;
            r_flash_phase <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_ped_pending <= w_ped_next;
            r_walk        <= w_walk_next;
            r_flash_phase <= w_flash_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_value = c_LONG_LOAD;
        w_walk_next  = r_walk;
        w_flash_next = r_flash_phase;
        w_ped_next   = r_ped_pending | (bus.ped_req && (r_state != FLASH));

        if (!bus.start && (r_state != FLASH)) begin
            w_next_state = FLASH;
            w_load       = 1'b1;
            w_load_value = c_SHORT_LOAD;
            w_flash_next = 1'b0;
            w_walk_next  = 1'b0;
            w_ped_next   = 1'b0;
        end else begin
            case (r_state)
                HWY_GREEN: begin
                    if (w_done && (bus.c || r_ped_pending)) begin
                        w_next_state = HWY_YELLOW;
                        w_load       = 1'b1;
                        w_load_value = c_SHORT_LOAD;
                    end
                end
                HWY_YELLOW: begin
                    // A request landing on the transfer cycle is served by this farm phase.
                    if (w_done) begin
                        w_next_state = FARM_GREEN;
                        w_load       = 1'b1;
                        w_load_value = c_LONG_LOAD;
                        w_walk_next  = r_ped_pending | bus.ped_req;
                        w_ped_next   = 1'b0;
                    end
                end
                FARM_GREEN: begin
                    if (w_done || (!bus.c && !r_walk)) begin
                        w_next_state = FARM_YELLOW;
                        w_load       = 1'b1;
                        w_load_value = c_SHORT_LOAD;
                    end
                end
                FARM_YELLOW: begin
                    if (w_done) begin
                        w_next_state = HWY_GREEN;
                        w_load       = 1'b1;
                        w_load_value = c_LONG_LOAD;
                        w_walk_next  = 1'b0;
                    end
                end
                FLASH: begin
                    if (bus.start) begin
                        w_next_state = HWY_GREEN;
                        w_load       = 1'b1;
                        w_load_value = c_LONG_LOAD;
                        w_flash_next = 1'b0;
                    end else if (w_done) begin
                        w_flash_next = ~r_flash_phase;
                        w_load       = 1'b1;
                        w_load_value = c_SHORT_LOAD;
                    end
                end
                default: begin
                    w_next_state = HWY_GREEN;
                    w_load       = 1'b1;
                    w_load_value = c_LONG_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        bus.HG   = 1'b0;
        bus.HY   = 1'b0;
        bus.HR   = 1'b0;
        bus.FG   = 1'b0;
        bus.FY   = 1'b0;
        bus.FR   = 1'b0;
        bus.WALK = 1'b0;
        case (r_state)
            HWY_GREEN:   begin bus.HG = 1'b1; bus.FR = 1'b1; end
            HWY_YELLOW:  begin bus.HY = 1'b1; bus.FR = 1'b1; end
            FARM_GREEN:  begin bus.HR = 1'b1; bus.FG = 1'b1; bus.WALK = r_walk; end
            FARM_YELLOW: begin bus.HR = 1'b1; bus.FY = 1'b1; end
            FLASH:       begin bus.HY = r_flash_phase; bus.FR = 1'b1; end
            default:     begin bus.HG = 1'b1; bus.FR = 1'b1; end
        endcase
    end

    assign bus.state = r_state;

endmodule : traffic_light_ctrl

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
// Module : tb_traffic_light_ctrl
// Brief  : Directed self-checking bench for traffic_light_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;
    import traffic_light_pkg::*;

    localparam logic [2:0] c_HG = 3'd0;
    localparam logic [2:0] c_HY = 3'd1;
    localparam logic [2:0] c_FG = 3'd2;
    localparam logic [2:0] c_FY = 3'd3;
    localparam logic [2:0] c_FL = 3'd4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(
        .CNT_W      (12),
        .LONG_TIME  (10),
        .SHORT_TIME (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp vector {HG,HY,HR,FG,FY,FR,WALK} expected for a given state.
    function automatic logic [6:0] exp_lamps(input logic [2:0] st, input logic fl, input logic wk);
        case (st)
            c_HG:    return 7'b1000010;
            c_HY:    return 7'b0100010;
            c_FG:    return {6'b001100, wk};
            c_FY:    return 7'b0010100;
            c_FL:    return {1'b0, fl, 5'b00010};
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] act_lamps();
        return {bus.HG, bus.HY, bus.HR, bus.FG, bus.FY, bus.FR, bus.WALK};
    endfunction

    task automatic do_reset();
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.c       = 1'b0;
        bus.ped_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            #1;
            n_checks++;
            if (bus.state !== c_HG || act_lamps() !== exp_lamps(c_HG, 1'b0, 1'b0))
                $display("FAIL reset_idle cyc=%0d state=%0d lamps=%b required state=%0d lamps=%b",
                         i, bus.state, act_lamps(), c_HG, exp_lamps(c_HG, 1'b0, 1'b0));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_car_held();
        logic [2:0] e;
        do_reset();
        bus.c = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if      (i < 10) e = c_HG;
            else if (i < 15) e = c_HY;
            else if (i < 25) e = c_FG;
            else if (i < 30) e = c_FY;
            else             e = c_HG;
            #1;
            n_checks++;
            if (bus.state !== e || act_lamps() !== exp_lamps(e, 1'b0, 1'b0))
                $display("FAIL car_held cyc=%0d state=%0d lamps=%b required state=%0d lamps=%b",
                         i, bus.state, act_lamps(), e, exp_lamps(e, 1'b0, 1'b0));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_car_pulse();
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if      (i < 13) e = c_HG;
            else if (i < 18) e = c_HY;
            else if (i < 19) e = c_FG;
            else if (i < 24) e = c_FY;
            else             e = c_HG;
            #1;
            n_checks++;
            if (bus.state !== e || act_lamps() !== exp_lamps(e, 1'b0, 1'b0))
                $display("FAIL car_pulse cyc=%0d state=%0d lamps=%b required state=%0d lamps=%b",
                         i, bus.state, act_lamps(), e, exp_lamps(e, 1'b0, 1'b0));
            else n_pass++;
            bus.c = (i == 12 || i == 13);
            @(negedge clk);
        end
        bus.c = 1'b0;
    endtask

    task automatic test_ped_walk();
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            if      (i < 10) e = c_HG;
            else if (i < 15) e = c_HY;
            else if (i < 25) e = c_FG;
            else if (i < 30) e = c_FY;
            else             e = c_HG;
            #1;
            n_checks++;
            if (bus.state !== e || act_lamps() !== exp_lamps(e, 1'b0, 1'b1))
                $display("FAIL ped_walk cyc=%0d state=%0d lamps=%b required state=%0d lamps=%b",
                         i, bus.state, act_lamps(), e, exp_lamps(e, 1'b0, 1'b1));
            else n_pass++;
            bus.ped_req = (i == 3);
            @(negedge clk);
        end
        bus.ped_req = 1'b0;
    endtask

    task automatic test_flash();
        logic [2:0] e;
        logic       f;
        do_reset();
        bus.c = 1'b1;
        for (int i = 0; i < 46; i++) begin
            f = 1'b0;
            if      (i < 10) e = c_HG;
            else if (i < 15) e = c_HY;
            else if (i < 18) e = c_FG;
            else if (i < 34) begin e = c_FL; f = ((i - 18) / 5) % 2 == 1; end
            else if (i < 44) e = c_HG;
            else             e = c_HY;
            #1;
            n_checks++;
            if (bus.state !== e || act_lamps() !== exp_lamps(e, f, 1'b0))
                $display("FAIL flash cyc=%0d state=%0d lamps=%b required state=%0d lamps=%b",
                         i, bus.state, act_lamps(), e, exp_lamps(e, f, 1'b0));
            else n_pass++;
            if (i == 17) bus.start = 1'b0;
            if (i == 33) bus.start = 1'b1;
            bus.ped_req = (i == 20);
            @(negedge clk);
        end
        bus.c       = 1'b0;
        bus.ped_req = 1'b0;
    endtask

    task automatic test_reset_mid_yellow();
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            e = (i < 10) ? c_HG : c_HY;
            #1;
            n_checks++;
            if (bus.state !== e)
                $display("FAIL pre_reset cyc=%0d state=%0d required %0d", i, bus.state, e);
            else n_pass++;
            bus.ped_req = (i == 2);
            @(negedge clk);
        end
        bus.ped_req = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.state !== c_HG || act_lamps() !== exp_lamps(c_HG, 1'b0, 1'b0))
            $display("FAIL async_reset state=%0d lamps=%b required state=0 lamps=%b",
                     bus.state, act_lamps(), exp_lamps(c_HG, 1'b0, 1'b0));
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            n_checks++;
            if (bus.state !== c_HG || act_lamps() !== exp_lamps(c_HG, 1'b0, 1'b0))
                $display("FAIL post_reset cyc=%0d state=%0d lamps=%b required state=0",
                         i, bus.state, act_lamps());
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.c       = 1'b0;
        bus.ped_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_car_held();
        test_car_pulse();
        test_ped_walk();
        test_flash();
        test_reset_mid_yellow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_traffic_light_ctrl

`default_nettype wire
